// File: rtl/manchester_pkg.sv
// Shared definitions for the sequential Manchester-carry add/subtract unit:
// FSM state encodings and the segment-index width helper.
package manchester_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index counter width: ceil(log2(nseg)), but never narrower than one bit.
  function automatic int idx_width(input int nseg);
    int w;
    w = 1;
    while ((1 << w) < nseg) w++;
    return w;
  endfunction

endpackage

// File: rtl/manchester_segment.sv
// One SEG-bit slice of a Manchester carry chain built from per-bit
// kill/propagate/generate cells; purely combinational.
module manchester_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  // Each cell owns its own carry wires so the chain is a clean
  // bit-to-bit ripple rather than a self-referencing vector.
  for (genvar i = 0; i < SEG; i++) begin : g_bit
    logic p, g, k;
    logic c_in_w, c_out_w;

    if (i == 0) begin : g_first
      assign c_in_w = cin;
    end else begin : g_next
      assign c_in_w = g_bit[i-1].c_out_w;
    end

    assign p       = a[i] ^ b[i];
    assign g       = a[i] & b[i];
    assign k       = ~(a[i] | b[i]);
    assign c_out_w = k ? 1'b0 : (p ? c_in_w : g);
    assign s[i]    = p ^ c_in_w;
  end

  assign cout  = g_bit[SEG-1].c_out_w;
  assign c_msb = g_bit[SEG-1].c_in_w;

endmodule

// File: rtl/manchester_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit resolving one SEG-bit segment per
// clock, LSB segment first, with valid/ready handshakes on both sides.
module manchester_seq_adder
  import manchester_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int             NSEG     = WIDTH / SEG;
  localparam int             IW       = idx_width(NSEG);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NSEG - 1);

  if (WIDTH % SEG != 0) begin : g_bad_params
    $error("manchester_seq_adder: WIDTH must be a multiple of SEG");
  end

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;

  logic [SEG-1:0]   seg_a;
  logic [SEG-1:0]   seg_b;
  logic [SEG-1:0]   seg_s;
  logic             seg_cout;
  logic             seg_c_msb;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign seg_a = op_a[int'(idx)*SEG +: SEG];
  assign seg_b = op_b[int'(idx)*SEG +: SEG];

  manchester_segment #(.SEG(SEG)) u_segment (
    .a     (seg_a),
    .b     (seg_b),
    .cin   (carry),
    .s     (seg_s),
    .cout  (seg_cout),
    .c_msb (seg_c_msb)
  );

  // Subtraction is folded in at accept time: invert y and force carry-in,
  // so the BUSY datapath only ever performs an add.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a  <= x;
            op_b  <= y ^ {WIDTH{sub}};
            carry <= sub | carry_in;
            idx   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          sum[int'(idx)*SEG +: SEG] <= seg_s;
          carry                     <= seg_cout;
          if (idx == LAST_IDX) begin
            carry_out <= seg_cout;
            overflow  <= seg_c_msb ^ seg_cout;
            state     <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_seq_adder.sv
// Directed self-checking bench for manchester_seq_adder (WIDTH=16, SEG=4).
module tb_manchester_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        carry_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  manchester_seq_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Drives one operation from an idle unit, scrambles the inputs after the
  // accepting edge, waits (bounded) for the result, samples it and consumes it.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, output logic [15:0] rs, output logic rco,
                        output logic rov, output int lat);
    x = a; y = b; carry_in = ci; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; x = ~a; y = ~b; carry_in = ~ci; sub = ~s;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rco = carry_out; rov = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = 16'h0; y = 16'h0; carry_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    vectors++;
    if (sum !== 16'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got sum=%h co=%b ov=%b want 0000 0 0", sum, carry_out, overflow);
    end
  endtask

  task automatic test_add();
    logic [15:0] ta[5]  = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h00FF, 16'h8000};
    logic [15:0] tb[5]  = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'h8000};
    logic        tci[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] ts[5]  = '{16'h5555, 16'h0000, 16'h8000, 16'h0100, 16'h0000};
    logic        tco[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        tov[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] rs;
    logic        rco, rov;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tci[i], 1'b0, rs, rco, rov, lat);
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("[TB] FAIL add_latency[%0d] got %0d edges want 4", i, lat);
      end
      vectors++;
      if (rs !== ts[i] || rco !== tco[i] || rov !== tov[i]) begin
        miscompares++;
        $display("[TB] FAIL add[%0d] got sum=%h co=%b ov=%b want %h %b %b",
                 i, rs, rco, rov, ts[i], tco[i], tov[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] ta[3]  = '{16'h0005, 16'h8000, 16'h1234};
    logic [15:0] tb[3]  = '{16'h0007, 16'h0001, 16'h1234};
    logic        tci[3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ts[3]  = '{16'hFFFE, 16'h7FFF, 16'h0000};
    logic        tco[3] = '{1'b0, 1'b1, 1'b1};
    logic        tov[3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] rs;
    logic        rco, rov;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tci[i], 1'b1, rs, rco, rov, lat);
      vectors++;
      if (lat !== 4 || rs !== ts[i] || rco !== tco[i] || rov !== tov[i]) begin
        miscompares++;
        $display("[TB] FAIL sub[%0d] got lat=%0d sum=%h co=%b ov=%b want 4 %h %b %b",
                 i, lat, rs, rco, rov, ts[i], tco[i], tov[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    x = 16'h1111; y = 16'h2222; carry_in = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat !== 4 || sum !== 16'h3333 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_first got lat=%0d sum=%h co=%b ov=%b want 4 3333 0 0",
               lat, sum, carry_out, overflow);
    end
    x = 16'hA000; y = 16'h6000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3333 ||
          carry_out !== 1'b0 || overflow !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d] got ov_valid=%b in_ready=%b sum=%h co=%b ov=%b want 1 0 3333 0 0",
                 i, out_valid, in_ready, sum, carry_out, overflow);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat !== 4 || sum !== 16'h0000 || carry_out !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_second got lat=%0d sum=%h co=%b ov=%b want 4 0000 1 0",
               lat, sum, carry_out, overflow);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] rs;
    logic        rco, rov;
    int          lat;
    int          seen;
    x = 16'hFFFF; y = 16'hFFFF; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 ||
        carry_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state got in_ready=%b out_valid=%b sum=%h co=%b ov=%b want 1 0 0000 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_result got %0d valid cycles want 0", seen);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rco, rov, lat);
    vectors++;
    if (lat !== 4 || rs !== 16'h0100 || rco !== 1'b0 || rov !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_next got lat=%0d sum=%h co=%b ov=%b want 4 0100 0 0",
               lat, rs, rco, rov);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, bb, exp_s, rs;
    logic [16:0] full;
    logic        ci, s, exp_co, exp_ov, rco, rov;
    int          lat;
    for (int i = 0; i < 20; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      s  = 1'($urandom);
      bb = s ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {16'h0, (s ? 1'b1 : ci)};
      exp_s  = full[15:0];
      exp_co = full[16];
      exp_ov = (a[15] == bb[15]) && (exp_s[15] != a[15]);
      run_op(a, b, ci, s, rs, rco, rov, lat);
      vectors++;
      if (lat !== 4 || rs !== exp_s || rco !== exp_co || rov !== exp_ov) begin
        miscompares++;
        $display("[TB] FAIL b2b[%0d] x=%h y=%h ci=%b sub=%b got lat=%0d sum=%h co=%b ov=%b want 4 %h %b %b",
                 i, a, b, ci, s, lat, rs, rco, rov, exp_s, exp_co, exp_ov);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready[%0d] got in_ready=%b want 1", i, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
